// File: rtl/ft_async_fifo_bridge.sv
// ft_async_fifo_bridge
// Bridges an FT245-style asynchronous FIFO port to a simple internal
// interface. Outgoing words are queued in a small TX buffer, and received
// words are delivered as one-cycle pulses. A single FSM with one shared
// down-counter sequences the RD_N and WR_N strobe phases. The phase lengths
// come from the ns parameters and are converted to clk cycles at elaboration.
// Optional build macro: FT_ROUND_ROBIN_EN. When it is defined, contention is
// arbitrated round-robin. When it is not defined, RX has strict priority.
module ft_async_fifo_bridge #(
    parameter int DATA          = 8,
    parameter int ADDR          = 4,
    parameter int FREQ_MHZ      = 200,
    parameter int T_RD_ACT_NS   = 50,
    parameter int T_RD_PRE_NS   = 50,
    parameter int T_WR_SETUP_NS = 5,
    parameter int T_WR_ACT_NS   = 50,
    parameter int T_WR_PRE_NS   = 50
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ext_wr,
    input  logic [DATA-1:0] ext_wr_data,
    output logic            ext_wr_full,
    input  logic            ext_rd,
    output logic            ext_rd_data_valid,
    output logic [DATA-1:0] ext_rd_data,
    input  logic            RXF_N,
    input  logic [DATA-1:0] ft_rd_data,
    output logic            RD_N,
    input  logic            TXE_N,
    output logic            WR_N,
    output logic [DATA-1:0] ft_wr_data,
    output logic            ft_wr_oe
);

    // ns -> cycles, rounded up, never shorter than one cycle
    function automatic int ns_to_cyc(input int ns);
        int c;
        c = (FREQ_MHZ * ns + 999) / 1000;
        return (c < 1) ? 1 : c;
    endfunction

    localparam int N_RD_ACT   = ns_to_cyc(T_RD_ACT_NS);
    localparam int N_RD_PRE   = ns_to_cyc(T_RD_PRE_NS);
    localparam int N_WR_SETUP = ns_to_cyc(T_WR_SETUP_NS);
    localparam int N_WR_ACT   = ns_to_cyc(T_WR_ACT_NS);
    localparam int N_WR_PRE   = ns_to_cyc(T_WR_PRE_NS);
    localparam int N_MAX_A    = (N_RD_ACT > N_RD_PRE) ? N_RD_ACT : N_RD_PRE;
    localparam int N_MAX_B    = (N_WR_ACT > N_WR_PRE) ? N_WR_ACT : N_WR_PRE;
    localparam int N_MAX_C    = (N_MAX_A > N_MAX_B) ? N_MAX_A : N_MAX_B;
    localparam int N_MAX      = (N_MAX_C > N_WR_SETUP) ? N_MAX_C : N_WR_SETUP;
    localparam int CNT_W      = $clog2(N_MAX + 1);
    localparam int DEPTH      = 1 << ADDR;

    typedef enum logic [2:0] {
        IDLE, RD_ACT, RD_PRE, WR_SETUP, WR_ACT, WR_PRE
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              rxf_s1, rxf_s2, txe_s1, txe_s2;
    logic [DATA-1:0]   mem [0:DEPTH-1];
    logic [ADDR:0]     wptr, rptr;
    logic              full, empty, push, pop;
    logic              rx_ok, tx_ok, grant_rx, grant_tx;
    logic              rd_capture, load_wr;

    // Two-flop synchronisers for the asynchronous FT status flags (idle = 1)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxf_s1 <= 1'b1;
            rxf_s2 <= 1'b1;
            txe_s1 <= 1'b1;
            txe_s2 <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
            rxf_s1 <= RXF_N;
            rxf_s2 <= rxf_s1;
            txe_s1 <= TXE_N;
            txe_s2 <= txe_s1;
        end
    end

    // TX buffer: full is taken from the registered pointers, so a push while full is dropped even if a pop happens in the same cycle
    assign full        = (wptr[ADDR] != rptr[ADDR]) &&
                         (wptr[ADDR-1:0] == rptr[ADDR-1:0]);
    assign empty       = (wptr == rptr);
    assign push        = ext_wr && !full;
    assign ext_wr_full = full;

    // TX buffer storage
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
        if (push)
            mem[wptr[ADDR-1:0]] <= ext_wr_data;
    end

    // TX buffer pointers with an extra wrap bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + (ADDR+1)'(1);
            if (pop)
                rptr <= rptr + (ADDR+1)'(1);
        end
    end

    assign rx_ok = !rxf_s2 && ext_rd;
    assign tx_ok = !txe_s2 && !empty;

`ifdef FT_ROUND_ROBIN_EN
    logic last_rx;

    // Records which direction was served last; starts as TX so RX wins the first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_rx <= 1'b0;
        else if (state == IDLE && (rx_ok || tx_ok))
            last_rx <= grant_rx;
    end

    assign grant_rx = rx_ok && (!tx_ok || !last_rx);
`else
    assign grant_rx = rx_ok;
`endif
    assign grant_tx = tx_ok && !grant_rx;

    // Next-state logic: each phase loads the counter with length-1 and leaves when it reaches zero
    always_comb begin
        // NOTE: defaults first so that every path assigns every output and no latch is inferred.
        state_nx   = state;
        cnt_nx     = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        rd_capture = 1'b0;
        load_wr    = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (grant_rx) begin
                    state_nx = RD_ACT;
                    cnt_nx   = CNT_W'(N_RD_ACT - 1);
                end else if (grant_tx) begin
                    state_nx = WR_SETUP;
                    cnt_nx   = CNT_W'(N_WR_SETUP - 1);
                    load_wr  = 1'b1;
                end
            end
            RD_ACT: begin
                if (cnt == '0) begin
                    state_nx   = RD_PRE;
                    cnt_nx     = CNT_W'(N_RD_PRE - 1);
                    rd_capture = 1'b1;
                end
            end
            RD_PRE: begin
                if (cnt == '0)
                    state_nx = IDLE;
            end
            WR_SETUP: begin
                if (cnt == '0) begin
                    state_nx = WR_ACT;
                    cnt_nx   = CNT_W'(N_WR_ACT - 1);
                end
            end
            WR_ACT: begin
                if (cnt == '0) begin
                    state_nx = WR_PRE;
                    cnt_nx   = CNT_W'(N_WR_PRE - 1);
                    pop      = 1'b1;
                end
            end
            WR_PRE: begin
                if (cnt == '0)
                    state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State and shared phase counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Registered FT strobes and data paths; both strobes decode from one next state, so they can never be low together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RD_N              <= 1'b1;
            WR_N              <= 1'b1;
            ft_wr_oe          <= 1'b0;
            ft_wr_data        <= '0;
            ext_rd_data       <= '0;
            ext_rd_data_valid <= 1'b0;
        end else begin
            RD_N              <= (state_nx != RD_ACT);
            WR_N              <= (state_nx != WR_ACT);
            ft_wr_oe          <= (state_nx == WR_SETUP) || (state_nx == WR_ACT);
            ext_rd_data_valid <= rd_capture;
            if (load_wr)
                ft_wr_data <= mem[rptr[ADDR-1:0]];
            if (rd_capture)
                ext_rd_data <= ft_rd_data;
        end
    end

endmodule

// File: tb/tb_ft_async_fifo_bridge.sv
// Directed bench for ft_async_fifo_bridge with default parameters.
// Each received word and each word driven onto the FT bus is checked against
// a queue of expected values. Phase lengths are measured directly.
module tb_ft_async_fifo_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       ext_wr;
    logic [7:0] ext_wr_data;
    logic       ext_wr_full;
    logic       ext_rd;
    logic       ext_rd_data_valid;
    logic [7:0] ext_rd_data;
    logic       rxf_n;
    logic [7:0] ft_rd_data;
    logic       rd_n;
    logic       txe_n;
    logic       wr_n;
    logic [7:0] ft_wr_data;
    logic       ft_wr_oe;

    int errors = 0;
    int checks = 0;
    int rd_starts = 0;
    int wr_starts = 0;
    logic [7:0] rd_q[$];
    logic [7:0] wr_q[$];

    always #5 clk = ~clk;

    ft_async_fifo_bridge dut (
        .clk(clk), .rst(rst),
        .ext_wr(ext_wr), .ext_wr_data(ext_wr_data), .ext_wr_full(ext_wr_full),
        .ext_rd(ext_rd), .ext_rd_data_valid(ext_rd_data_valid), .ext_rd_data(ext_rd_data),
        .RXF_N(rxf_n), .ft_rd_data(ft_rd_data), .RD_N(rd_n),
        .TXE_N(txe_n), .WR_N(wr_n), .ft_wr_data(ft_wr_data), .ft_wr_oe(ft_wr_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_word(input logic [7:0] d);
        ext_wr      = 1'b1;
        ext_wr_data = d;
        tick();
        ext_wr      = 1'b0;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return rd_n;
            1:       return wr_n;
            default: return ft_wr_oe;
        endcase
    endfunction

    // Counts ticks until the selected signal leaves level lvl (bounded)
    task automatic count_while(input int sel, input logic lvl, input int budget, output int n);
        n = 0;
        while (sig(sel) === lvl && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Read-side monitor: a valid pulse pops the expected-word queue, and a read-strobe start must not overlap a write
    logic rd_prev = 1'b1;
    logic val_prev = 1'b0;
    always @(negedge clk) begin
        if (rd_prev && !rd_n) begin
            rd_starts++;
            check("rd_strobe_overlap", wr_n, 1'b1);
        end
        if (ext_rd_data_valid) begin
            if (val_prev)
                flag("valid_not_pulse", ext_rd_data);
            else if (rd_q.size() == 0)
                flag("rd_unexpected", ext_rd_data);
            else
                check("rd_data", ext_rd_data, rd_q.pop_front());
        end
        rd_prev  = rd_n;
        val_prev = ext_rd_data_valid;
    end

    // Write-side monitor: each WR_N fall pops the expected-bus-word queue
    logic wr_prev = 1'b1;
    always @(negedge clk) begin
        if (wr_prev && !wr_n) begin
            wr_starts++;
            check("wr_strobe_overlap", rd_n, 1'b1);
            check("wr_oe_during_act", ft_wr_oe, 1'b1);
            if (wr_q.size() == 0)
                flag("wr_unexpected", ft_wr_data);
            else
                check("wr_data", ft_wr_data, wr_q.pop_front());
        end
        wr_prev = wr_n;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, w0, exp_w;
        rst = 1'b1; ext_wr = 1'b0; ext_wr_data = '0; ext_rd = 1'b1;
        rxf_n = 1'b0; txe_n = 1'b1; ft_rd_data = 8'hA5;

        // Reset state
        ticks(3);
        check("rst_rd_n", rd_n, 1'b1);
        check("rst_wr_n", wr_n, 1'b1);
        check("rst_oe", ft_wr_oe, 1'b0);
        check("rst_wr_data", ft_wr_data, 8'h00);
        check("rst_rd_data", ext_rd_data, 8'h00);
        check("rst_valid", ext_rd_data_valid, 1'b0);
        check("rst_full", ext_wr_full, 1'b0);

        // Reads with RXF_N low: the first read starts three cycles after release; 10 low, then 10 precharge + 1 idle
        rd_q.push_back(8'hA5);
        rd_q.push_back(8'h3C);
        base = rd_starts;
        @(negedge clk);
        rst = 1'b0;
        count_while(0, 1'b1, 20, n); check("rd_first_latency", n, 3);
        count_while(0, 1'b0, 40, n); check("rd_low_len", n, 10);
        count_while(0, 1'b1, 40, n); check("rd_gap_len", n, 11);
        // Second read: dropping ext_rd/RXF_N mid-read must not abort it
        ft_rd_data = 8'h3C; ext_rd = 1'b0; rxf_n = 1'b1;
        count_while(0, 1'b0, 40, n); check("rd2_low_len", n, 10);
        ticks(30);
        check("rd_count", rd_starts - base, 2);
        check("rd_q_drained", rd_q.size(), 0);
        check("rd_data_hold", ext_rd_data, 8'h3C);

        // ext_rd low blocks reads; raising it starts a read on the next cycle
        rxf_n = 1'b0; base = rd_starts;
        ticks(20);
        check("rd_blocked", rd_starts - base, 0);
        ft_rd_data = 8'h5A; rd_q.push_back(8'h5A); ext_rd = 1'b1;
        count_while(0, 1'b1, 10, n); check("rd_start_latency", n, 1);
        ext_rd = 1'b0; rxf_n = 1'b1;
        count_while(0, 1'b0, 40, n); check("rd3_low_len", n, 10);
        ticks(15);
        check("rd_q_drained2", rd_q.size(), 0);

        // Two writes: 1 setup, 10 strobe-low, then 10 recovery + 1 idle with oe low
        push_word(8'h11); wr_q.push_back(8'h11);
        push_word(8'h22); wr_q.push_back(8'h22);
        txe_n = 1'b0;
        count_while(2, 1'b0, 20, n); check("wr_start_latency", n, 3);
        count_while(1, 1'b1, 20, n); check("wr_setup_len", n, 1);
        count_while(1, 1'b0, 40, n); check("wr_low_len", n, 10);
        check("wr_pre_oe", ft_wr_oe, 1'b0);
        count_while(2, 1'b0, 40, n); check("wr_recovery_len", n, 11);
        txe_n = 1'b1;
        count_while(1, 1'b1, 20, n); check("wr2_setup_len", n, 1);
        count_while(1, 1'b0, 40, n); check("wr2_low_len", n, 10);
        ticks(30);
        check("wr_q_drained", wr_q.size(), 0);

        // Fill the buffer: full asserts the cycle after the 16th push, and a 17th push (0xFF) is dropped
        for (int i = 1; i <= 15; i++) begin
            push_word(8'(i));
            wr_q.push_back(8'(i));
        end
        check("full_at_15", ext_wr_full, 1'b0);
        push_word(8'h10); wr_q.push_back(8'h10);
        check("full_at_16", ext_wr_full, 1'b1);
        push_word(8'hFF);
        check("full_after_drop", ext_wr_full, 1'b1);
        txe_n = 1'b0;
        n = 0;
        while (wr_q.size() != 0 && n < 600) begin tick(); n++; end
        check("fill_drain_timeout", n < 600, 1'b1);
        check("full_cleared", ext_wr_full, 1'b0);
        ticks(30);
        txe_n = 1'b1;
        ticks(5);

        // Contention: both flags low and buffer loaded; count writes between the 1st and 3rd read
        push_word(8'h33); wr_q.push_back(8'h33);
        push_word(8'h44); wr_q.push_back(8'h44);
        ft_rd_data = 8'hA5;
        for (int i = 0; i < 3; i++) rd_q.push_back(8'hA5);
        base = rd_starts;
        rxf_n = 1'b0; txe_n = 1'b0; ext_rd = 1'b1;
        n = 0;
        while (rd_starts == base && n < 50) begin tick(); n++; end
        w0 = wr_starts;
        n = 0;
        while (rd_starts < base + 3 && n < 200) begin tick(); n++; end
        ext_rd = 1'b0; rxf_n = 1'b1;
`ifdef FT_ROUND_ROBIN_EN
        exp_w = 2;
`else
        exp_w = 0;
`endif
        check("contention_writes", wr_starts - w0, exp_w);
        n = 0;
        while ((wr_q.size() != 0 || rd_q.size() != 0) && n < 300) begin tick(); n++; end
        check("contention_drain_timeout", n < 300, 1'b1);
        txe_n = 1'b1;
        ticks(30);

        // Reset in the 4th RD_ACT cycle: strobe released at once; no delivery; buffer emptied
        push_word(8'h77);
        ft_rd_data = 8'h99; rxf_n = 1'b0; ext_rd = 1'b1;
        count_while(0, 1'b1, 10, n); check("rd_rst_start", n, 3);
        ticks(3);
        rst = 1'b1;
        #1;
        check("rst_mid_rd_n", rd_n, 1'b1);
        check("rst_mid_valid", ext_rd_data_valid, 1'b0);
        check("rst_mid_rd_data", ext_rd_data, 8'h00);
        check("rst_mid_full", ext_wr_full, 1'b0);
        rxf_n = 1'b1; ext_rd = 1'b0; txe_n = 1'b0;
        ticks(2);
        w0 = wr_starts;
        @(negedge clk);
        rst = 1'b0;
        ticks(40);
        check("rst_buffer_empty", wr_starts - w0, 0);
        check("rst_no_delivery", ext_rd_data, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ft_async_fifo_bridge.md
FT_ASYNC_FIFO_BRIDGE -- requirements
Module: ft_async_fifo_bridge

Interface
REQ-001 SHALL have parameter DATA, default 8: data width of all data ports.
REQ-002 SHALL have parameter ADDR, default 4: TX buffer depth is 2^ADDR words.
REQ-003 SHALL have parameter FREQ_MHZ, default 200: clk frequency used for timing conversion.
REQ-004 SHALL have parameters T_RD_ACT_NS=50, T_RD_PRE_NS=50, T_WR_SETUP_NS=5, T_WR_ACT_NS=50, T_WR_PRE_NS=50: FT strobe phase durations in ns.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 ext_wr  in  1  push ext_wr_data into TX buffer.
REQ-008 ext_wr_data  in  DATA  word to transmit.
REQ-009 ext_wr_full  out  1  TX buffer full.
REQ-010 ext_rd  in  1  consumer ready; RX transfers start only while high.
REQ-011 ext_rd_data_valid  out  1  one-cycle pulse, ext_rd_data valid.
REQ-012 ext_rd_data  out  DATA  received word.
REQ-013 RXF_N  in  1  FT RX data available, active-low, asynchronous.
REQ-014 ft_rd_data  in  DATA  FT read bus.
REQ-015 RD_N  out  1  FT read strobe, active-low.
REQ-016 TXE_N  in  1  FT TX space available, active-low, asynchronous.
REQ-017 WR_N  out  1  FT write strobe, active-low.
REQ-018 ft_wr_data  out  DATA  FT write bus.
REQ-019 ft_wr_oe  out  1  high while bridge drives ft_wr_data.

Function
REQ-020 SHALL convert each ns parameter to cycles N = max(1, ceil(FREQ_MHZ*ns/1000)), elaborated as constants.
REQ-021 SHALL pass RXF_N and TXE_N through 2-flop synchronisers; all decisions use synchronised values.
REQ-022 SHALL implement states IDLE, RD_ACT, RD_PRE, WR_SETUP, WR_ACT, WR_PRE with one shared down-counter.
REQ-023 IDLE: rx_ok = !RXF_N_sync & ext_rd; tx_ok = !TXE_N_sync & TX buffer non-empty; RX chosen when both, except as REQ-041.
REQ-024 IDLE->RD_ACT: RD_N low next cycle, held low N(T_RD_ACT) cycles.
REQ-025 Last RD_ACT cycle SHALL capture ft_rd_data into ext_rd_data and pulse ext_rd_data_valid the following cycle; ext_rd_data holds until next capture.
REQ-026 RD_ACT->RD_PRE: RD_N high N(T_RD_PRE) cycles, then IDLE.
REQ-027 IDLE->WR_SETUP: head word onto ft_wr_data, ft_wr_oe high, WR_N high, N(T_WR_SETUP) cycles.
REQ-028 WR_ACT: WR_N low N(T_WR_ACT) cycles, data stable; buffer popped on WR_ACT exit.
REQ-029 WR_PRE: WR_N high, ft_wr_oe low, N(T_WR_PRE) cycles, then IDLE.
REQ-030 RD_N and WR_N SHALL never be low together; both registered, glitch-free.
REQ-031 TX buffer: ext_wr pushes when not full; full evaluated before same-cycle pop, so push on full is dropped.
REQ-032 ext_wr_full SHALL assert the cycle after the 2^ADDR-th unpopped push; pointers wrap modulo 2^ADDR with an extra wrap bit.
REQ-033 RXF_N/TXE_N deassertion mid-transfer SHALL NOT abort the transfer.
REQ-034 ext_rd deassertion mid-read SHALL NOT abort; the word is still delivered.

Reset
REQ-035 rst SHALL immediately force RD_N=1, WR_N=1, ft_wr_oe=0, ft_wr_data=0, ext_rd_data=0, ext_rd_data_valid=0, state IDLE, counter 0.
REQ-036 rst SHALL empty the TX buffer (ext_wr_full=0) and set synchronisers to 1; rst mid-transfer abandons it without data delivery.
REQ-037 After rst release, first FT transaction no earlier than 3 cycles later.

Configuration
REQ-038 Macro FT_ROUND_ROBIN_EN SHALL select arbitration.
REQ-039 Without it: RX strictly prioritised when rx_ok and tx_ok both true.
REQ-040 With it: a last-served flag (reset to TX) grants the opposite direction on contention.
REQ-041 Either mode: an uncontended request is granted immediately.

Verification
REQ-042 Defaults, RXF_N low, ext_rd=1, ft_rd_data=0xA5 -> RD_N low 10 cycles, valid pulse with 0xA5, RD_N high 10 cycles before next read.
REQ-043 Push 0x11,0x22, TXE_N low -> per word 1 setup, 10 WR_N-low, 10 recovery cycles; bus shows 0x11 then 0x22.
REQ-044 16 pushes, TXE_N high -> ext_wr_full=1; 17th push (0xFF) dropped, never appears on ft_wr_data.
REQ-045 RXF_N and TXE_N low continuously, buffer loaded -> without macro only reads; with macro strict read/write alternation.
REQ-046 rst pulsed in cycle 4 of RD_ACT -> RD_N high same cycle, no valid pulse, buffer empty.
REQ-047 ext_rd=0, RXF_N low -> RD_N stays high; raising ext_rd starts read within 2 cycles.
